// File: rtl/fp_pkg.sv
// Shared types and constants for the half-precision float to int16 converter.
package fp_pkg;

  localparam int unsigned FLT_W        = 16;
  localparam int unsigned INT_W        = 16;
  localparam int unsigned SIGN_BIT     = 15;
  localparam int unsigned EXP_W        = 5;
  localparam int unsigned MAN_W_DEF    = 10;
  localparam int unsigned EXP_BIAS_DEF = 15;
  localparam int unsigned EXP_INFNAN   = 31;
  localparam int unsigned K_W          = 4;

  localparam logic [INT_W-1:0] INT_MAX = 16'h7FFF;
  localparam logic [INT_W-1:0] INT_MIN = 16'h8000;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FIX
  } state_t;

  // Operand class decides how the FIX step selects the result
  typedef enum logic [1:0] {
    CLS_NORM,
    CLS_SAT,
    CLS_MIN
  } cls_t;

  typedef struct packed {
    cls_t             cls;
    logic [K_W-1:0]   k;
    logic             dir_right;
    logic [INT_W-1:0] mag;
    logic             inexact;
  } cls_res_t;

endpackage

// File: rtl/flt2int_classify.sv
// Combinational decode of a float operand into class, shift count/direction and start values.
module flt2int_classify
  import fp_pkg::*;
#(
  parameter int unsigned EXP_BIAS = EXP_BIAS_DEF,
  parameter int unsigned MAN_W    = MAN_W_DEF
) (
  input  logic [FLT_W-1:0] flt,
  output cls_res_t         res
);

  // Exponent at which the significand already sits at integer weight
  localparam logic [EXP_W-1:0] E_ONE   = EXP_W'(EXP_BIAS);
  localparam logic [EXP_W-1:0] E_UNITY = EXP_W'(EXP_BIAS + MAN_W);
  localparam logic [EXP_W-1:0] E_SAT   = EXP_W'(EXP_BIAS + INT_W - 1);

  logic             sign;
  logic [EXP_W-1:0] e;
  logic [MAN_W-1:0] m;

  assign sign = flt[SIGN_BIT];
  assign e    = flt[SIGN_BIT-1 -: EXP_W];
  assign m    = flt[MAN_W-1:0];

  // Classify by exponent range
  always_comb begin
    res.cls       = CLS_NORM;
    res.k         = '0;
    res.dir_right = 1'b0;
    res.mag       = INT_W'({1'b1, m});
    res.inexact   = 1'b0;
    if (e == '0) begin
      res.mag     = '0;
      res.inexact = (m != '0);
    end else if (e < E_ONE) begin
      res.mag     = '0;
      res.inexact = 1'b1;
    end else if (e >= E_SAT) begin
      // -2^15 is the only representable value at the saturation exponent
      if ((e != EXP_W'(EXP_INFNAN)) && sign && (m == '0)) begin
        res.cls = CLS_MIN;
      end else begin
        res.cls = CLS_SAT;
      end
    end else if (e < E_UNITY) begin
      res.dir_right = 1'b1;
      res.k         = K_W'(E_UNITY - e);
    end else if (e > E_UNITY) begin
      res.k = K_W'(e - E_UNITY);
    end
  end

endmodule

// File: rtl/flt2int_engine.sv
// Multi-cycle float16 to int16 converter (truncate toward zero) with start/done handshake.
module flt2int_engine
  import fp_pkg::*;
#(
  parameter int unsigned EXP_BIAS = EXP_BIAS_DEF,
  parameter int unsigned MAN_W    = MAN_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [FLT_W-1:0] flt_in,
  output logic             busy,
  output logic             done,
  output logic [INT_W-1:0] int_out,
  output logic             ovf,
  output logic             inexact
);

  state_t           state, state_d;
  cls_res_t         cls_c;
  cls_t             cls_q;
  logic             sign_q;
  logic             dir_q;
  logic [K_W-1:0]   k_q;
  logic [INT_W-1:0] mag_q;
  logic             sticky_q;
  logic             busy_d;
  logic             done_d;
  logic [INT_W-1:0] result_c;

  flt2int_classify #(
    .EXP_BIAS (EXP_BIAS),
    .MAN_W    (MAN_W)
  ) u_classify (
    .flt (flt_in),
    .res (cls_c)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next state and handshake outputs; SHIFT tests the count before shifting,
  // so every operation spends at least one cycle there
  always_comb begin
    state_d = state;
    busy_d  = busy;
    done_d  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
          busy_d  = 1'b1;
        end
      end
      SHIFT: begin
        if (k_q == '0) begin
          state_d = FIX;
        end
      end
      FIX: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Final result selection from the shifted magnitude
  always_comb begin
    case (cls_q)
      CLS_SAT: result_c = sign_q ? INT_MIN : INT_MAX;
      CLS_MIN: result_c = INT_MIN;
      default: result_c = sign_q ? (INT_W'(0) - mag_q) : mag_q;
    endcase
  end

  // Operand capture, one-bit-per-cycle shifter with sticky, and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cls_q    <= CLS_NORM;
      sign_q   <= 1'b0;
      dir_q    <= 1'b0;
      k_q      <= '0;
      mag_q    <= '0;
      sticky_q <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      int_out  <= '0;
      ovf      <= 1'b0;
      inexact  <= 1'b0;
    end else begin
      busy <= busy_d;
      done <= done_d;
      case (state)
        IDLE: begin
          if (start) begin
            sign_q   <= flt_in[SIGN_BIT];
            cls_q    <= cls_c.cls;
            dir_q    <= cls_c.dir_right;
            k_q      <= cls_c.k;
            mag_q    <= cls_c.mag;
            sticky_q <= cls_c.inexact;
          end
        end
        SHIFT: begin
          if (k_q != '0) begin
            k_q <= k_q - K_W'(1);
            if (dir_q) begin
              mag_q    <= mag_q >> 1;
              sticky_q <= sticky_q | mag_q[0];
            end else begin
              mag_q <= mag_q << 1;
            end
          end
        end
        FIX: begin
          int_out <= result_c;
          ovf     <= (cls_q == CLS_SAT);
          inexact <= sticky_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_flt2int_engine.sv
// Self-checking bench for flt2int_engine: vector table, random operands, control corner cases.
module tb_flt2int_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] flt_in;
  logic        busy;
  logic        done;
  logic [15:0] int_out;
  logic        ovf;
  logic        inexact;

  flt2int_engine dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .flt_in  (flt_in),
    .busy    (busy),
    .done    (done),
    .int_out (int_out),
    .ovf     (ovf),
    .inexact (inexact)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] flt;
    logic [15:0] iv;
    logic        ov;
    logic        ix;
    int          lat;
  } vec_t;

  typedef struct {
    vec_t v;
    int   acc;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   done_seen = 0;
  vec_t tab[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Arithmetic reference: value = 1.m * 2^(e-15), truncated, then saturated to int16
  function automatic vec_t model(input logic [15:0] f);
    vec_t   r;
    int     e;
    longint sig;
    longint mag;
    e     = int'(f[14:10]);
    sig   = 1024 + longint'(f[9:0]);
    r.flt = f;
    r.ov  = 1'b0;
    r.ix  = 1'b0;
    if (e == 0) begin
      mag  = 0;
      r.ix = (f[9:0] != 10'd0);
    end else if (e >= 25) begin
      mag = sig << (e - 25);
    end else begin
      mag  = sig >> (25 - e);
      r.ix = (sig % (longint'(1) << (25 - e))) != 0;
    end
    if (!f[15] && mag > 32767) begin
      r.iv = 16'h7FFF;
      r.ov = 1'b1;
      r.ix = 1'b0;
    end else if (f[15] && mag > 32768) begin
      r.iv = 16'h8000;
      r.ov = 1'b1;
      r.ix = 1'b0;
    end else begin
      r.iv = f[15] ? 16'(-mag) : 16'(mag);
    end
    if (e >= 15 && e <= 24)      r.lat = 27 - e;
    else if (e >= 26 && e <= 29) r.lat = e - 23;
    else                         r.lat = 2;
    return r;
  endfunction

  // Scoreboard consumer: every Done pops one expected result
  always @(negedge clk) begin
    if (!reset && done) begin
      done_seen++;
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done got int_out=0x%0h expected no done", int_out);
      end else begin
        mon_e = sbq.pop_front();
        check($sformatf("int_out[%h]", mon_e.v.flt), 32'(int_out), 32'(mon_e.v.iv));
        check($sformatf("ovf[%h]", mon_e.v.flt), 32'(ovf), 32'(mon_e.v.ov));
        check($sformatf("inexact[%h]", mon_e.v.flt), 32'(inexact), 32'(mon_e.v.ix));
        check($sformatf("latency[%h]", mon_e.v.flt), 32'(cyc - mon_e.acc), 32'(mon_e.v.lat));
        check($sformatf("busy_at_done[%h]", mon_e.v.flt), 32'(busy), 32'd0);
      end
    end
  end

  // Drive one request; the next rising edge is the accepting edge 0
  task automatic issue(input vec_t v);
    exp_t x;
    start  = 1'b1;
    flt_in = v.flt;
    @(posedge clk);
    #1;
    start = 1'b0;
    x.v   = v;
    x.acc = cyc;
    sbq.push_back(x);
  endtask

  task automatic wait_idle(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (sbq.size() == 0) break;
    end
    if (sbq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout got %0d pending expected 0", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_int_out"}, 32'(int_out), 32'd0);
    check({tag, "_ovf"}, 32'(ovf), 32'd0);
    check({tag, "_inexact"}, 32'(inexact), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int seen0;
    logic [15:0] rf;
    tab[0]  = '{16'h3C00, 16'h0001, 1'b0, 1'b0, 12};
    tab[1]  = '{16'hC500, 16'hFFFB, 1'b0, 1'b0, 10};
    tab[2]  = '{16'h3E00, 16'h0001, 1'b0, 1'b1, 12};
    tab[3]  = '{16'h3800, 16'h0000, 1'b0, 1'b1, 2};
    tab[4]  = '{16'h7400, 16'h4000, 1'b0, 1'b0, 6};
    tab[5]  = '{16'h7BFF, 16'h7FFF, 1'b1, 1'b0, 2};
    tab[6]  = '{16'hF800, 16'h8000, 1'b0, 1'b0, 2};
    tab[7]  = '{16'hFC00, 16'h8000, 1'b1, 1'b0, 2};
    tab[8]  = '{16'h8000, 16'h0000, 1'b0, 1'b0, 2};
    tab[9]  = '{16'h0001, 16'h0000, 1'b0, 1'b1, 2};
    tab[10] = '{16'h6400, 16'h0400, 1'b0, 1'b0, 2};
    tab[11] = '{16'h7C01, 16'h7FFF, 1'b1, 1'b0, 2};
    tab[12] = '{16'h4000, 16'h0002, 1'b0, 1'b0, 11};
    tab[13] = '{16'h6BFF, 16'h0FFE, 1'b0, 1'b0, 3};
    tab[14] = '{16'hBFFF, 16'hFFFF, 1'b0, 1'b1, 12};

    reset  = 1'b1;
    start  = 1'b0;
    flt_in = 16'h0000;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check_zero_outputs("reset");

    foreach (tab[i]) begin
      @(negedge clk);
      issue(tab[i]);
      wait_idle(40);
    end

    for (int i = 0; i < 40; i++) begin
      rf = 16'($urandom);
      @(negedge clk);
      issue(model(rf));
      wait_idle(40);
    end

    // A second Start mid-conversion must be dropped
    @(negedge clk);
    issue(tab[0]);
    repeat (3) @(negedge clk);
    start  = 1'b1;
    flt_in = 16'h7BFF;
    @(negedge clk);
    start = 1'b0;
    wait_idle(40);
    repeat (15) @(negedge clk);

    // Back-to-back: new Start during the Done cycle is accepted
    @(negedge clk);
    issue(tab[3]);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) break;
    end
    issue(tab[12]);
    wait_idle(40);

    // Reset on edge 5 of a 1.0 conversion abandons it with no Done
    @(negedge clk);
    issue(tab[5]);
    wait_idle(40);
    @(negedge clk);
    issue(tab[0]);
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    sbq.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_zero_outputs("midreset");
    seen0 = done_seen;
    repeat (20) @(negedge clk);
    check("midreset_no_done", 32'(done_seen - seen0), 32'd0);

    @(negedge clk);
    issue(tab[0]);
    wait_idle(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
